// File: rtl/eq_stream_checker.sv
// Masked equality checker for two WIDTH-bit sample streams with saturating
// match/miss statistics, first-mismatch capture and a SEARCH/LOCKED/FAIL monitor.
module eq_stream_checker #(
  parameter int WIDTH    = 32,
  parameter int LOCK_LEN = 4,
  parameter int MAX_ERR  = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] mask,
  output logic             eq,
  output logic             eq_valid,
  output logic             locked,
  output logic             fail,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic             first_miss_vld,
  output logic [WIDTH-1:0] first_miss_a,
  output logic [WIDTH-1:0] first_miss_b
);

  localparam int RUN_W = $clog2(LOCK_LEN + 1);
  localparam int ERR_W = $clog2(MAX_ERR + 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_LOCKED = 2'd1,
    ST_FAIL   = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [RUN_W-1:0]   run_cnt_reg, run_cnt_next;
  logic [ERR_W-1:0]   err_run_reg, err_run_next;
  logic               eq_reg, eq_next;
  logic               eq_valid_reg;
  logic [CNT_W-1:0]   match_cnt_reg, match_cnt_next;
  logic [CNT_W-1:0]   miss_cnt_reg, miss_cnt_next;
  logic               first_miss_vld_reg, first_miss_vld_next;
  logic [WIDTH-1:0]   first_miss_a_reg, first_miss_a_next;
  logic [WIDTH-1:0]   first_miss_b_reg, first_miss_b_next;

  logic               hit;
  logic [RUN_W-1:0]   run_inc;
  logic [ERR_W-1:0]   err_inc;

  assign hit     = ((a ^ b) & mask) == '0;
  assign run_inc = run_cnt_reg + RUN_W'(1);
  assign err_inc = err_run_reg + ERR_W'(1);

  always_comb begin
    state_next          = state_reg;
    run_cnt_next        = run_cnt_reg;
    err_run_next        = err_run_reg;
    eq_next             = eq_reg;
    match_cnt_next      = match_cnt_reg;
    miss_cnt_next       = miss_cnt_reg;
    first_miss_vld_next = first_miss_vld_reg;
    first_miss_a_next   = first_miss_a_reg;
    first_miss_b_next   = first_miss_b_reg;

    if (valid) begin
      eq_next = hit;
      if (hit) begin
        if (match_cnt_reg != {CNT_W{1'b1}})
          match_cnt_next = match_cnt_reg + CNT_W'(1);
      end else begin
        if (miss_cnt_reg != {CNT_W{1'b1}})
          miss_cnt_next = miss_cnt_reg + CNT_W'(1);
        if (!first_miss_vld_reg) begin
          first_miss_vld_next = 1'b1;
          first_miss_a_next   = a;
          first_miss_b_next   = b;
        end
      end

      case (state_reg)
        ST_SEARCH: begin
          if (!hit) begin
            run_cnt_next = '0;
          end else if (run_inc == RUN_W'(LOCK_LEN)) begin
            // Run counter is spent once locked; err_run starts fresh.
            run_cnt_next = '0;
            err_run_next = '0;
            state_next   = ST_LOCKED;
          end else begin
            run_cnt_next = run_inc;
          end
        end
        ST_LOCKED: begin
          if (hit) begin
            err_run_next = '0;
          end else if (err_inc == ERR_W'(MAX_ERR)) begin
            err_run_next = '0;
            state_next   = ST_FAIL;
          end else begin
            err_run_next = err_inc;
          end
        end
        default: state_next = ST_FAIL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg          <= ST_SEARCH;
      run_cnt_reg        <= '0;
      err_run_reg        <= '0;
      eq_reg             <= 1'b0;
      eq_valid_reg       <= 1'b0;
      match_cnt_reg      <= '0;
      miss_cnt_reg       <= '0;
      first_miss_vld_reg <= 1'b0;
      first_miss_a_reg   <= '0;
      first_miss_b_reg   <= '0;
    end else if (clear) begin
      // Clear wins over a coincident sample, which is dropped uncounted.
      state_reg          <= ST_SEARCH;
      run_cnt_reg        <= '0;
      err_run_reg        <= '0;
      eq_reg             <= 1'b0;
      eq_valid_reg       <= 1'b0;
      match_cnt_reg      <= '0;
      miss_cnt_reg       <= '0;
      first_miss_vld_reg <= 1'b0;
      first_miss_a_reg   <= '0;
      first_miss_b_reg   <= '0;
    end else begin
      state_reg          <= state_next;
      run_cnt_reg        <= run_cnt_next;
      err_run_reg        <= err_run_next;
      eq_reg             <= eq_next;
      eq_valid_reg       <= valid;
      match_cnt_reg      <= match_cnt_next;
      miss_cnt_reg       <= miss_cnt_next;
      first_miss_vld_reg <= first_miss_vld_next;
      first_miss_a_reg   <= first_miss_a_next;
      first_miss_b_reg   <= first_miss_b_next;
    end
  end

  assign eq             = eq_reg;
  assign eq_valid       = eq_valid_reg;
  assign locked         = (state_reg == ST_LOCKED);
  assign fail           = (state_reg == ST_FAIL);
  assign match_cnt      = match_cnt_reg;
  assign miss_cnt       = miss_cnt_reg;
  assign first_miss_vld = first_miss_vld_reg;
  assign first_miss_a   = first_miss_a_reg;
  assign first_miss_b   = first_miss_b_reg;

endmodule

// File: tb/tb_eq_stream_checker.sv
// Bench for eq_stream_checker: a default instance and a CNT_W=4 instance share
// one stimulus stream and are checked against a sample-history reference model.
module tb_eq_stream_checker;

  localparam int LOCK_LEN = 4;
  localparam int MAX_ERR  = 3;

  logic        clk = 1'b0;
  logic        reset, clear, valid;
  logic [31:0] a, b, mask;

  logic        eq0, ev0, lk0, fl0, fv0;
  logic [15:0] mc0, xc0;
  logic [31:0] fa0, fb0;
  logic        eq1, ev1, lk1, fl1, fv1;
  logic [3:0]  mc1, xc1;
  logic [31:0] fa1, fb1;

  always #5 clk = ~clk;

  eq_stream_checker dut (
    .clk(clk), .reset(reset), .clear(clear), .valid(valid),
    .a(a), .b(b), .mask(mask),
    .eq(eq0), .eq_valid(ev0), .locked(lk0), .fail(fl0),
    .match_cnt(mc0), .miss_cnt(xc0),
    .first_miss_vld(fv0), .first_miss_a(fa0), .first_miss_b(fb0)
  );

  eq_stream_checker #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .clear(clear), .valid(valid),
    .a(a), .b(b), .mask(mask),
    .eq(eq1), .eq_valid(ev1), .locked(lk1), .fail(fl1),
    .match_cnt(mc1), .miss_cnt(xc1),
    .first_miss_vld(fv1), .first_miss_a(fa1), .first_miss_b(fb1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: list of valid-sample outcomes since the last reset/clear.
  bit          hist[$];
  bit          eq_m, ev_m, fv_m;
  logic [31:0] fa_m, fb_m;

  task automatic model_reset();
    hist.delete();
    eq_m = 0; ev_m = 0; fv_m = 0; fa_m = '0; fb_m = '0;
  endtask

  task automatic model_sample(input bit v, input bit c, input logic [31:0] ia, ib, im);
    bit h;
    if (c) begin
      model_reset();
      return;
    end
    ev_m = v;
    if (v) begin
      h = (((ia ^ ib) & im) == 32'd0);
      hist.push_back(h);
      eq_m = h;
      if (!h && !fv_m) begin
        fv_m = 1; fa_m = ia; fb_m = ib;
      end
    end
  endtask

  // Locked once some window of LOCK_LEN consecutive samples were all hits;
  // failed once, after that point, MAX_ERR consecutive samples were all misses.
  function automatic void exp_fsm(output bit lk, output bit fl);
    int  lock_i = -1;
    bit  all;
    lk = 0; fl = 0;
    for (int i = LOCK_LEN - 1; i < hist.size(); i++) begin
      all = 1;
      for (int k = 0; k < LOCK_LEN; k++) if (!hist[i-k]) all = 0;
      if (all) begin lock_i = i; break; end
    end
    if (lock_i < 0) return;
    for (int j = lock_i + MAX_ERR; j < hist.size(); j++) begin
      all = 1;
      for (int k = 0; k < MAX_ERR; k++) if (hist[j-k]) all = 0;
      if (all) begin fl = 1; break; end
    end
    lk = !fl;
  endfunction

  function automatic int count_of(input bit val);
    int n = 0;
    foreach (hist[i]) if (hist[i] == val) n++;
    return n;
  endfunction

  function automatic longint sat(input int n, input int max);
    return (n > max) ? max : n;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    bit lk, fl;
    int nm, nx;
    exp_fsm(lk, fl);
    nm = count_of(1);
    nx = count_of(0);
    cmp({tag, " eq"}, 64'(eq0), 64'(eq_m));
    cmp({tag, " eq_valid"}, 64'(ev0), 64'(ev_m));
    cmp({tag, " locked"}, 64'(lk0), 64'(lk));
    cmp({tag, " fail"}, 64'(fl0), 64'(fl));
    cmp({tag, " match_cnt"}, 64'(mc0), sat(nm, 65535));
    cmp({tag, " miss_cnt"}, 64'(xc0), sat(nx, 65535));
    cmp({tag, " first_miss_vld"}, 64'(fv0), 64'(fv_m));
    cmp({tag, " first_miss_a"}, 64'(fa0), 64'(fa_m));
    cmp({tag, " first_miss_b"}, 64'(fb0), 64'(fb_m));
    cmp({tag, " s.eq"}, 64'(eq1), 64'(eq_m));
    cmp({tag, " s.eq_valid"}, 64'(ev1), 64'(ev_m));
    cmp({tag, " s.locked"}, 64'(lk1), 64'(lk));
    cmp({tag, " s.fail"}, 64'(fl1), 64'(fl));
    cmp({tag, " s.match_cnt"}, 64'(mc1), sat(nm, 15));
    cmp({tag, " s.miss_cnt"}, 64'(xc1), sat(nx, 15));
    cmp({tag, " s.first_miss_vld"}, 64'(fv1), 64'(fv_m));
    cmp({tag, " s.first_miss_a"}, 64'(fa1), 64'(fa_m));
    cmp({tag, " s.first_miss_b"}, 64'(fb1), 64'(fb_m));
  endtask

  task automatic step(input string tag, input bit v, input bit c,
                      input logic [31:0] ia, ib, im);
    valid = v; clear = c; a = ia; b = ib; mask = im;
    @(posedge clk);
    model_sample(v, c, ia, ib, im);
    #1;
    check_all(tag);
  endtask

  typedef struct {
    bit          v, c;
    logic [31:0] a, b, m;
    bit          e_eq, e_lk, e_fl;
    int          e_mc, e_xc;
  } vec_t;

  vec_t tbl[40];
  int   ntbl = 0;

  task automatic addv(input bit v, c, input logic [31:0] ia, ib, im,
                      input bit e_eq, e_lk, e_fl, input int e_mc, e_xc);
    tbl[ntbl] = '{v, c, ia, ib, im, e_eq, e_lk, e_fl, e_mc, e_xc};
    ntbl++;
  endtask

  localparam logic [31:0] H  = 32'h1234_5678;
  localparam logic [31:0] F  = 32'hFFFF_FFFF;
  localparam logic [31:0] MK = 32'hFFFF_FF00;

  initial begin
    // Lock after four hits
    addv(1,0,H,H,F, 1,0,0,1,0); addv(1,0,H,H,F, 1,0,0,2,0);
    addv(1,0,H,H,F, 1,0,0,3,0); addv(1,0,H,H,F, 1,1,0,4,0);
    addv(0,1,0,0,0, 0,0,0,0,0);
    // Broken run
    addv(1,0,H,H,F, 1,0,0,1,0); addv(1,0,H,H,F, 1,0,0,2,0);
    addv(1,0,H,H,F, 1,0,0,3,0); addv(1,0,1,0,F, 0,0,0,3,1);
    addv(1,0,H,H,F, 1,0,0,4,1); addv(1,0,H,H,F, 1,0,0,5,1);
    addv(1,0,H,H,F, 1,0,0,6,1); addv(1,0,H,H,F, 1,1,0,7,1);
    // Fail from LOCKED, then sticky, then clear
    addv(1,0,1,0,F, 0,1,0,7,2); addv(1,0,1,0,F, 0,1,0,7,3);
    addv(1,0,H,H,F, 1,1,0,8,3); addv(1,0,1,0,F, 0,1,0,8,4);
    addv(1,0,1,0,F, 0,1,0,8,5); addv(1,0,1,0,F, 0,0,1,8,6);
    addv(1,0,H,H,F, 1,0,1,9,6); addv(1,0,H,H,F, 1,0,1,10,6);
    addv(0,1,0,0,0, 0,0,0,0,0);
    // Masked hits with gaps
    addv(1,0,32'hFF,0,MK, 1,0,0,1,0); addv(0,0,0,0,0, 1,0,0,1,0);
    addv(1,0,32'hFF,0,MK, 1,0,0,2,0); addv(0,0,0,0,0, 1,0,0,2,0);
    addv(1,0,32'hFF,0,MK, 1,0,0,3,0); addv(0,0,0,0,0, 1,0,0,3,0);
    addv(1,0,32'hFF,0,MK, 1,1,0,4,0); addv(1,0,32'h100,0,MK, 0,1,0,4,1);
    addv(1,0,F,0,0, 1,1,0,5,1);       addv(0,1,0,0,0, 0,0,0,0,0);

    reset = 1; clear = 0; valid = 0; a = '0; b = '0; mask = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 0;

    for (int i = 0; i < ntbl; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      step(t, tbl[i].v, tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].m);
      cmp({t, " tbl.eq"}, 64'(eq0), 64'(tbl[i].e_eq));
      cmp({t, " tbl.eq_valid"}, 64'(ev0), 64'(tbl[i].v && !tbl[i].c));
      cmp({t, " tbl.locked"}, 64'(lk0), 64'(tbl[i].e_lk));
      cmp({t, " tbl.fail"}, 64'(fl0), 64'(tbl[i].e_fl));
      cmp({t, " tbl.match_cnt"}, 64'(mc0), 64'(tbl[i].e_mc));
      cmp({t, " tbl.miss_cnt"}, 64'(xc0), 64'(tbl[i].e_xc));
    end

    // Saturation, then clear beating a coincident miss
    for (int i = 0; i < 20; i++) step("sat_hit", 1, 0, H, H, F);
    cmp("sat match_cnt4", 64'(mc1), 64'd15);
    cmp("sat match_cnt16", 64'(mc0), 64'd20);
    step("sat_miss", 1, 0, 32'h1, 32'h0, F);
    step("clr_prio", 1, 1, 32'h1, 32'h0, F);
    cmp("clr_prio miss_cnt", 64'(xc0), 64'd0);
    cmp("clr_prio first_miss_vld", 64'(fv0), 64'd0);
    for (int i = 0; i < 20; i++) step("sat_miss", 1, 0, 32'h5, 32'h0, F);
    cmp("sat miss_cnt4", 64'(xc1), 64'd15);
    step("clr", 0, 1, 0, 0, 0);

    // Asynchronous reset between edges while locked with live counters
    for (int i = 0; i < 4; i++) step("pre_rst", 1, 0, H, H, F);
    step("pre_rst_miss", 1, 0, 32'hA, 32'hB, F);
    cmp("pre_rst locked", 64'(lk0), 64'd1);
    #3;
    reset = 1;
    #1;
    model_reset();
    check_all("async_rst");
    #1;
    reset = 0;
    for (int i = 0; i < 4; i++) step("post_rst", 1, 0, H, H, F);
    cmp("relock", 64'(lk0), 64'd1);

    // Randomised traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] ra, rb, rm;
      bit v, c;
      v  = ($urandom_range(0, 9) < 7);
      c  = ($urandom_range(0, 49) == 0);
      ra = $urandom;
      rm = ($urandom_range(0, 3) == 0) ? 32'($urandom) : F;
      rb = ra;
      if ($urandom_range(0, 3) == 0) rb = ra ^ (32'h1 << $urandom_range(0, 31));
      step("rand", v, c, ra, rb, rm);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
